// File: rtl/render_pkg.sv
// Shared definitions for the renderer framebuffer writer: region geometry,
// pixel type, writer FSM states and the region address helper.
package render_pkg;

    localparam int START_X_DEF     = 260;
    localparam int START_Y_DEF     = 195;
    localparam int END_X_DEF       = 390;
    localparam int END_Y_DEF       = 295;
    localparam int REGION_W        = END_X_DEF - START_X_DEF;
    localparam int REGION_H        = END_Y_DEF - START_Y_DEF;
    localparam int FB_DEPTH        = REGION_W * REGION_H;
    localparam int PIXEL_WIDTH_DEF = 24;
    localparam int ADDR_WIDTH_DEF  = 14;

    typedef logic [23:0] pixel_t;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } fb_wr_state_t;

    // Linear offset of (h, v) inside the region, at full 32-bit width.
    function automatic logic [31:0] region_offset(input logic [10:0] h,
                                                  input logic [9:0]  v,
                                                  input int          sx,
                                                  input int          sy,
                                                  input int          w);
        return (32'(h) - 32'(sx)) + (32'(v) - 32'(sy)) * 32'(w);
    endfunction

endpackage

// File: rtl/render_fb_writer_if.sv
// Pixel stream from the renderer: AXI-stream beat plus its screen coordinates.
interface render_fb_writer_if #(
    parameter int PIXEL_WIDTH = 24
);
    logic [PIXEL_WIDTH-1:0] pixel_axis_tdata;
    logic                   pixel_axis_tvalid;
    logic                   pixel_axis_tready;
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;

    modport master (
        output pixel_axis_tdata,
        output pixel_axis_tvalid,
        output hcount_in,
        output vcount_in,
        input  pixel_axis_tready
    );

    modport slave (
        input  pixel_axis_tdata,
        input  pixel_axis_tvalid,
        input  hcount_in,
        input  vcount_in,
        output pixel_axis_tready
    );
endinterface

// File: rtl/render_fb_writer_tracker.sv
// Raster position tracker: holds the next expected in-region coordinate,
// compares the incoming beat against it and flags the last region pixel.
module fb_raster_tracker #(
    parameter int START_X = 260,
    parameter int START_Y = 195,
    parameter int END_X   = 390,
    parameter int END_Y   = 295
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_in,
    input  logic [9:0]  v_in,
    input  logic        advance_in,
    input  logic        restart_in,
    output logic        match_out,
    output logic        last_out
);

    logic [10:0] exp_h_q, exp_h_d;
    logic [9:0]  exp_v_q, exp_v_d;
    logic [10:0] base_h;
    logic [9:0]  base_v;

    // Next expected position: a restart steps from the region origin, an advance from the current expectation.
    always_comb begin
        base_h  = restart_in ? 11'(START_X) : exp_h_q;
        base_v  = restart_in ? 10'(START_Y) : exp_v_q;
        exp_h_d = exp_h_q;
        exp_v_d = exp_v_q;
        if (advance_in || restart_in) begin
            if (base_h == 11'(END_X - 1)) begin
                exp_h_d = 11'(START_X);
                exp_v_d = (base_v == 10'(END_Y - 1)) ? 10'(START_Y) : base_v + 10'd1;
            end else begin
                exp_h_d = base_h + 11'd1;
                exp_v_d = base_v;
            end
        end
    end

    // Coordinate compare and last-pixel detection on the incoming beat.
    always_comb begin
        match_out = (h_in == exp_h_q) && (v_in == exp_v_q);
        last_out  = (h_in == 11'(END_X - 1)) && (v_in == 10'(END_Y - 1));
    end

    // Expected-position registers, starting at the region origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_h_q <= 11'(START_X);
            exp_v_q <= 10'(START_Y);
        end else begin
            exp_h_q <= exp_h_d;
            exp_v_q <= exp_v_d;
        end
    end

endmodule

// File: rtl/render_fb_writer.sv
// Framebuffer write-port driver: aligns to frame start, checks raster order,
// and registers accepted region pixels onto port A of the framebuffer BRAM.
module render_fb_writer
    import render_pkg::*;
#(
    parameter int START_X     = START_X_DEF,
    parameter int START_Y     = START_Y_DEF,
    parameter int END_X       = END_X_DEF,
    parameter int END_Y       = END_Y_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    render_fb_writer_if.slave      pixel_axis,
    input  logic                   stall_in,
    output logic [ADDR_WIDTH-1:0]  wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] wr_data_out,
    output logic                   wr_en_out,
    output logic                   frame_done_out,
    output logic [15:0]            frame_count_out,
    output logic [15:0]            drop_count_out,
    output logic                   order_err_out
);

    fb_wr_state_t           state_q, state_d;
    logic                   alive_q, alive_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   order_err_q, order_err_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic [15:0]            drop_count_q, drop_count_d;

    logic        tready;
    logic        accept;
    logic        in_region;
    logic        at_start;
    logic        match;
    logic        last;
    logic        do_write;
    logic        advance;
    logic        restart;
    logic        err;
    logic        drop;
    logic [31:0] offset;

    fb_raster_tracker #(
        .START_X (START_X),
        .START_Y (START_Y),
        .END_X   (END_X),
        .END_Y   (END_Y)
    ) u_tracker (
        .clk        (aclk),
        .rst_n      (aresetn),
        .h_in       (pixel_axis.hcount_in),
        .v_in       (pixel_axis.vcount_in),
        .advance_in (advance),
        .restart_in (restart),
        .match_out  (match),
        .last_out   (last)
    );

    // Handshake, region classification and address of the current beat.
    always_comb begin
        tready    = alive_q && (!wr_valid_q || !stall_in);
        accept    = pixel_axis.pixel_axis_tvalid && tready;
        in_region = (pixel_axis.hcount_in >= 11'(START_X)) && (pixel_axis.hcount_in < 11'(END_X)) &&
                    (pixel_axis.vcount_in >= 10'(START_Y)) && (pixel_axis.vcount_in < 10'(END_Y));
        at_start  = (pixel_axis.hcount_in == 11'(START_X)) && (pixel_axis.vcount_in == 10'(START_Y));
        offset    = region_offset(pixel_axis.hcount_in, pixel_axis.vcount_in,
                                  START_X, START_Y, END_X - START_X);
    end

    // Writer FSM: decide per accepted beat whether to write, drop or resync.
    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        advance  = 1'b0;
        restart  = 1'b0;
        err      = 1'b0;
        drop     = 1'b0;
        if (accept) begin
            case (state_q)
                SYNC: begin
                    if (at_start) begin
                        do_write = 1'b1;
                        restart  = 1'b1;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (!in_region) begin
                        drop = 1'b1;
                    end else if (match) begin
                        do_write = 1'b1;
                        advance  = 1'b1;
                    end else if (at_start) begin
                        do_write = 1'b1;
                        restart  = 1'b1;
                    end else begin
                        err     = 1'b1;
                        state_d = SYNC;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // Output register, status pulses and counters for the next cycle.
    always_comb begin
        alive_d       = 1'b1;
        wr_valid_d    = wr_valid_q && stall_in;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        order_err_d   = err;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        if (do_write) begin
            wr_valid_d   = 1'b1;
            wr_addr_d    = ADDR_WIDTH'(offset);
            wr_data_d    = pixel_axis.pixel_axis_tdata;
            frame_done_d = last;
            if (last) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // State and output registers; reset discards any pending write.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= SYNC;
            alive_q       <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            order_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
            drop_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            alive_q       <= alive_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            order_err_q   <= order_err_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign pixel_axis.pixel_axis_tready = tready;
    assign wr_en_out       = wr_valid_q && !stall_in;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign frame_done_out  = frame_done_q;
    assign order_err_out   = order_err_q;
    assign frame_count_out = frame_count_q;
    assign drop_count_out  = drop_count_q;

endmodule

// File: doc/render_fb_writer.md
# render_fb_writer

Pixel-stream sink that receives the renderer's AXI-stream output (pixel plus its screen coordinates) and turns it into write-port traffic for the renderer framebuffer BRAM. It sits between the renderer's pixel output and port A of the dual-port framebuffer, replacing inline address arithmetic. It aligns to frame start, checks raster order, and reports frame completion and stream errors.

## Interface

**Parameters**
- START_X, 260: first column of the 3D region (inclusive).
- START_Y, 195: first row of the 3D region (inclusive).
- END_X, 390: column bound (exclusive).
- END_Y, 295: row bound (exclusive).
- PIXEL_WIDTH, 24: pixel width, {R,G,B} 8 bits each.
- ADDR_WIDTH, 14: framebuffer address width; must hold (END_X-START_X)*(END_Y-START_Y)-1.

**Ports**
- aclk, input, 1: single clock.
- aresetn, input, 1: reset, asynchronous, active-low.
- pixel_axis_tdata, input, PIXEL_WIDTH: pixel from renderer.
- pixel_axis_tvalid, input, 1: beat valid.
- pixel_axis_tready, output, 1: beat accepted when tvalid && tready.
- hcount_in, input, 11: column of the current beat; qualified by tvalid.
- vcount_in, input, 10: row of the current beat; qualified by tvalid.
- stall_in, input, 1: write port cannot take a write this cycle.
- wr_addr_out, output, ADDR_WIDTH: framebuffer write address.
- wr_data_out, output, PIXEL_WIDTH: framebuffer write data.
- wr_en_out, output, 1: write strobe.
- frame_done_out, output, 1: one-cycle pulse on the write of the last region pixel.
- frame_count_out, output, 16: completed frames, wrapping.
- drop_count_out, output, 16: accepted out-of-region beats, saturating.
- order_err_out, output, 1: one-cycle pulse when raster-order resync occurs.

## Operation

- **Region test.** in_region = START_X ≤ h < END_X and START_Y ≤ v < END_Y.
- **Address.** addr = (h−START_X) + (v−START_Y)·(END_X−START_X).
  - Computed at full width, then truncated to ADDR_WIDTH.
  - Width W = END_X−START_X is a constant multiplier.
- **Expected position.** Counters exp_h and exp_v track the next expected in-region coordinate.
  - Advance: exp_h increments; when exp_h reaches END_X it wraps to START_X and exp_v increments.
  - When exp_v reaches END_Y, both wrap to (START_X, START_Y).
- **FSM state SYNC** (reset state).
  - Accepted beats are discarded and not counted.
  - A beat at exactly (START_X, START_Y) is written, exp advances, and the FSM moves to RUN.
- **FSM state RUN, in-region beat:**
  - If the coordinate equals exp: write it and advance exp.
  - If it does not match: do not write, pulse order_err_out, go to SYNC.
  - Exception: a mismatched beat at (START_X, START_Y) is written, and the FSM stays in RUN with exp reloaded to (START_X+1, START_Y).
- **FSM state RUN, out-of-region beat:** not written; drop_count_out increments and saturates at 0xFFFF; state is unchanged.
- **Frame completion.** A write at (END_X−1, END_Y−1) pulses frame_done_out and increments frame_count_out, which wraps from 0xFFFF to 0. The FSM stays in RUN.

## Timing

- **Output register.** One output register stage holds wr_valid, wr_addr_out and wr_data_out.
  - wr_en_out = wr_valid && !stall_in.
  - pixel_axis_tready = !wr_valid || !stall_in.
- **Latency.** A beat accepted at edge N appears on the write port after edge N, i.e. in cycle N+1. frame_done_out and order_err_out are aligned to that same cycle.
- **Stall.** While stall_in is high, the register, address and data hold. frame_done_out still pulses only once, on the first cycle the register is loaded.
- **Simultaneous drain and accept.** A register drain and a new accept in the same cycle are allowed (full throughput, 1 beat/cycle).
- **Reset values.** wr_en_out=0, wr_addr_out=0, wr_data_out=0, frame_done_out=0, order_err_out=0, both counts 0, pixel_axis_tready=0, FSM=SYNC, exp=(START_X, START_Y). pixel_axis_tready rises in the first cycle after reset deassertion.
- **Reset mid-frame.** Reset asserted mid-frame discards the pending write. After release, the block realigns on the next (START_X, START_Y) beat.

## Structure

- Shared package render_pkg holds:
  - the region constants (default START/END values, derived width/height, FB_DEPTH);
  - the typedef pixel_t (logic [23:0]);
  - the typedef fb_wr_state_t enum {SYNC, RUN}.
- Natural sub-module: fb_raster_tracker, owning exp_h/exp_v, the match compare, and the last-pixel flag.
- No other sub-modules.

## Test plan

- **Alignment.** Reset, then stream beats (0,0)…(259,195), then (260,195) with data 0xABCDEF.
  - Only (260,195) is written, at addr 0, one cycle after acceptance.
  - drop_count_out stays 0.
- **Full frame.** Stream a complete 130×100 raster with no stall.
  - 13000 writes, addr 0..12999 in order.
  - frame_done_out pulses with addr 12999.
  - frame_count_out=1.
- **Backpressure.** Hold stall_in high for 3 cycles mid-frame with tvalid high.
  - tready=0 while the register is full.
  - The address/data held stable are written once after release; no beat lost or duplicated.
- **Out-of-region in RUN.** Send (100,200) while in RUN.
  - No write, drop_count_out=1, state stays RUN.
  - After 0x10000 such beats, drop_count_out holds at 0xFFFF.
- **Order error.** In RUN with exp=(270,200), send (275,200).
  - order_err_out pulses, no write, FSM=SYNC.
  - The next (260,195) beat resumes writing at addr 0.
- **Async reset mid-frame.** Assert aresetn low mid-frame, between clock edges.
  - All outputs go to reset values immediately.
  - No write occurs until (260,195) is seen.
